// File: rtl/inst_fetch_pkg.sv
// Shared ISA constants and helpers for the fetch stage.
//   ISA__XLEN            : architectural register / address width
//   ISA__NOP             : canonical NOP (addi x0, x0, 0)
//   ISA__INST_ALIGN_MASK : PC bits that must be zero for a legal fetch
//   ISA__INST_BYTES      : PC increment per sequential instruction
package inst_fetch_pkg;

    localparam int unsigned ISA__XLEN            = 32;
    localparam logic [31:0] ISA__NOP             = 32'h0000_0013;
    localparam logic [31:0] ISA__INST_ALIGN_MASK = 32'h0000_0003;
    localparam logic [31:0] ISA__INST_BYTES      = 32'h0000_0004;

    function automatic logic is_misaligned(input logic [ISA__XLEN-1:0] addr);
        return |(addr & ISA__INST_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage. Owns the PC, issues word reads over a req/ack
// port and holds the fetched word for the decoder until it is consumed.
// Handles redirects, a level-sensitive debug halt and fetch faults.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   mem_req/mem_addr   : fetch request and address (held until mem_ack)
//   mem_rdata/mem_ack  : returned word and completion strobe
//   mem_err            : bus error, valid only with mem_ack
//   inst/pc/inst_valid : held instruction, its address, and its qualifier
//   fetch_fault        : held instruction is an access fault (inst = 0)
//   inst_ready         : consumer accepts the held instruction
//   redirect/_pc       : load a new fetch PC (highest priority)
//   halt_req/halted    : debug halt request and acknowledge
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic [ISA__XLEN-1:0] mem_addr,
    input  logic [ISA__XLEN-1:0] mem_rdata,
    input  logic                 mem_ack,
    input  logic                 mem_err,
    output logic [ISA__XLEN-1:0] inst,
    output logic [ISA__XLEN-1:0] pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic                 fetch_fault,
    input  logic                 redirect,
    input  logic [ISA__XLEN-1:0] redirect_pc,
    input  logic                 halt_req,
    output logic                 halted
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StDiscard
    } state_e;

    state_e               state_q, state_d;
    logic [ISA__XLEN-1:0] pc_q, pc_d;
    logic [ISA__XLEN-1:0] inst_q, inst_d;
    logic [ISA__XLEN-1:0] addr_q;
    logic                 fault_q, fault_d;
    logic                 mem_req_q, mem_req_d;
    logic                 inst_valid_q, inst_valid_d;
    logic                 halted_q, halted_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;

        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    // Stay idle one cycle so the new PC gets its alignment check.
                    pc_d = redirect_pc;
                end else if (halt_req) begin
                    state_d = StIdle;
                end else if (is_misaligned(pc_q)) begin
                    state_d = StHold;
                    fault_d = 1'b1;
                    inst_d  = '0;
                end else begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    // An unacked transfer must still be drained at its old address.
                    state_d = mem_ack ? StIdle : StDiscard;
                end else if (mem_ack) begin
                    inst_d  = mem_err ? '0 : mem_rdata;
                    fault_d = mem_err;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = StIdle;
                end else if (inst_ready) begin
                    pc_d    = pc_q + ISA__INST_BYTES;
                    state_d = StIdle;
                end
            end
            StDiscard: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (mem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        mem_req_d    = (state_d == StReq) || (state_d == StDiscard);
        inst_valid_d = (state_d == StHold);
        halted_d     = (state_q == StIdle) && halt_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_VECTOR;
            inst_q       <= ISA__NOP;
            addr_q       <= RESET_VECTOR;
            fault_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            fault_q      <= fault_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
            // Remember the address in flight; a redirect moves pc while the
            // outstanding transfer must keep its original address.
            if (state_q == StReq) begin
                addr_q <= pc_q;
            end
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = (state_q == StDiscard) ? addr_q : pc_q;
    assign inst        = inst_q;
    assign pc          = pc_q;
    assign inst_valid  = inst_valid_q;
    assign fetch_fault = fault_q;
    assign halted      = halted_q;

endmodule
